// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/exec/mem/wb.
// Optional signed-overflow trap in ALU_WB when CTRL_OVF_TRAP_EN is defined.
module mips_mc_ctrl #(
  parameter int RESET_STATE_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              instr,
  input  logic                     zf,
  input  logic                     of,
  input  logic                     mem_ready,
  output logic [3:0]               alu_op,
  output logic [1:0]               alu_src_a,
  output logic [1:0]               alu_src_b,
  output logic                     imm_zext,
  output logic                     pc_we,
  output logic [1:0]               pc_src,
  output logic                     ir_we,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic                     iord,
  output logic                     reg_we,
  output logic                     reg_dst,
  output logic                     mem_to_reg,
  output logic                     ill_instr,
  output logic                     ovf_trap,
  output logic [RESET_STATE_W-1:0] dbg_state
);

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_NOR  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;

  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLTU = 6'h2B;

  state_e state_q, state_d;

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_instr;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign unused_instr = ^instr[25:6];

  logic [3:0] r_op;
  logic       r_ok;
  logic [3:0] i_op;
  logic       i_ok;
  logic       i_zext;

  always_comb begin
    r_op = ALU_ADD;
    r_ok = 1'b1;
    case (fn)
      F_SLL:  r_op = ALU_SLL;
      F_ADD:  r_op = ALU_ADD;
      F_ADDU: r_op = ALU_ADD;
      F_SUB:  r_op = ALU_SUB;
      F_SUBU: r_op = ALU_SUB;
      F_AND:  r_op = ALU_AND;
      F_OR:   r_op = ALU_OR;
      F_XOR:  r_op = ALU_XOR;
      F_NOR:  r_op = ALU_NOR;
      F_SLTU: r_op = ALU_SLTU;
      default: r_ok = 1'b0;
    endcase
  end

  always_comb begin
    i_op   = ALU_ADD;
    i_ok   = 1'b1;
    i_zext = 1'b0;
    case (op)
      OP_ADDI:  i_op = ALU_ADD;
      OP_ADDIU: i_op = ALU_ADD;
      OP_SLTIU: i_op = ALU_SLTU;
      OP_ANDI: begin
        i_op   = ALU_AND;
        i_zext = 1'b1;
      end
      OP_ORI: begin
        i_op   = ALU_OR;
        i_zext = 1'b1;
      end
      OP_XORI: begin
        i_op   = ALU_XOR;
        i_zext = 1'b1;
      end
      default: i_ok = 1'b0;
    endcase
  end

  logic is_r, is_i, is_mem, is_br, is_j, is_sll;

  assign is_r   = (op == OP_R) && r_ok;
  assign is_i   = i_ok;
  assign is_mem = (op == OP_LW) || (op == OP_SW);
  assign is_br  = (op == OP_BEQ) || (op == OP_BNE);
  assign is_j   = (op == OP_J);
  assign is_sll = (fn == F_SLL);

  logic trap_hit;

`ifdef CTRL_OVF_TRAP_EN
  // ALU flag is only valid while the EXEC state drives the ALU
  logic of_q;
  logic trap_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      of_q <= 1'b0;
    end else if (state_q == S_EXEC_R || state_q == S_EXEC_I) begin
      of_q <= of;
    end
  end

  assign trap_ok  = ((op == OP_R) && (fn == F_ADD || fn == F_SUB))
                 || (op == OP_ADDI);
  assign trap_hit = trap_ok & of_q;
`else
  logic unused_of;

  assign unused_of = of;
  assign trap_hit  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    alu_op     = ALU_AND;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    imm_zext   = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    ir_we      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    ill_instr  = 1'b0;
    ovf_trap   = 1'b0;
    unique case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        unique case (1'b1)
          is_r:   state_d = S_EXEC_R;
          is_i:   state_d = S_EXEC_I;
          is_mem: state_d = S_MEM_ADDR;
          is_br:  state_d = S_BRANCH;
          is_j:   state_d = S_JUMP;
          default: begin
            ill_instr = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = is_sll ? 2'b10 : 2'b01;
        alu_op    = r_op;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        imm_zext  = i_zext;
        alu_op    = i_op;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_we   = ~trap_hit;
        ovf_trap = trap_hit;
        reg_dst  = (op == OP_R);
        state_d  = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        state_d   = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_op    = ALU_SUB;
        pc_src    = 2'b01;
        pc_we     = (op == OP_BNE) ? ~zf : zf;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_we   = 1'b1;
        pc_src  = 2'b10;
        state_d = S_FETCH;
      end
      default: state_d = S_INIT;
    endcase
  end

  assign dbg_state = RESET_STATE_W'(state_q);

endmodule
